// File: rtl/mdio_responder_if.sv
// Pin and fabric bundle of the Clause-22 MDIO responder; slave = responder, master = initiator/fabric side.
interface mdio_responder_if;
  logic        mdc_in;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_en;
  logic [15:0] status_in;
  logic [15:0] ctrl_out;
  logic        wr_strobe;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic        busy;
  logic [2:0]  dbg_state;

  // wr_strobe is a valid-only, one-clk event with no ready: wr_addr/wr_data are
  // meaningful exactly on that cycle and the consumer must take them then.
  modport master (
    output mdc_in, mdio_in, status_in,
    input  mdio_out, mdio_en, ctrl_out, wr_strobe, wr_addr, wr_data, frame_err, busy, dbg_state
  );
  modport slave (
    input  mdc_in, mdio_in, status_in,
    output mdio_out, mdio_en, ctrl_out, wr_strobe, wr_addr, wr_data, frame_err, busy, dbg_state
  );
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder with a small register file.
// Optional: MDIO_PREAMBLE_SUPPRESS_EN allows 1-bit preamble after a valid frame.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR      = 5'd1,
  parameter int          NREGS         = 8,
  parameter logic [15:0] PHY_ID1       = 16'h0022,
  parameter logic [15:0] PHY_ID2       = 16'h1560,
  parameter int          PREAMBLE_BITS = 32,
  parameter int          TIMEOUT       = 4096
) (
  input logic             clk,
  input logic             rst,
  mdio_responder_if.slave bus
);
  typedef enum logic [2:0] {S_HUNT, S_HDR, S_READ, S_WRITE, S_IGNORE} state_t;

  localparam int PW = $clog2(PREAMBLE_BITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t        state_q, state_d;
  logic          mdc_s1_q, mdc_s2_q, mdc_prev_q, mdio_s1_q, mdio_s2_q;
  logic [PW-1:0] pre_q;
  logic [TW-1:0] tmr_q;
  logic [4:0]    bit_q;
  logic [11:0]   hdr_q;
  logic [4:0]    regad_q;
  logic [15:0]   rdata_q;
  logic [14:0]   wsh_q;
  logic          ta_ok_q;
  logic          mdio_out_q, mdio_en_q, wr_strobe_q, frame_err_q;
  logic [4:0]    wr_addr_q;
  logic [15:0]   wr_data_q;
  logic [15:0]   regs_q [NREGS];

  logic          rise, mdio_s, hdr_done, hdr_bad, last_bit, timeout;
  logic [12:0]   hdr_full;
  logic [15:0]   wdata_full, rd_mux;
  logic          busy_c, frame_err_d, wr_fire;
  logic [PW-1:0] need;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic supp_q;
  assign need = supp_q ? PW'(1) : PW'(PREAMBLE_BITS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              supp_q <= 1'b0;
    else if (frame_err_d) supp_q <= 1'b0;
    else if (wr_fire || (state_q == S_READ && last_bit)) supp_q <= 1'b1;
  end
`else
  assign need = PW'(PREAMBLE_BITS);
`endif

  assign rise       = mdc_s2_q & ~mdc_prev_q;
  assign mdio_s     = mdio_s2_q;
  // {ST bit 1, OP[1:0], PHYAD[4:0], REGAD[4:0]} as of the bit-13 edge
  assign hdr_full   = {hdr_q, mdio_s};
  assign hdr_bad    = !hdr_full[12] || (hdr_full[11:10] == 2'b00) || (hdr_full[11:10] == 2'b11);
  assign hdr_done   = rise && (state_q == S_HDR) && (bit_q == 5'd13);
  assign last_bit   = rise && (bit_q == 5'd31);
  assign timeout    = (state_q != S_HUNT) && !rise && (tmr_q == TW'(TIMEOUT - 1));
  assign wdata_full = {wsh_q, mdio_s};

  always_comb begin
    rd_mux = 16'h0000;
    if (int'(hdr_full[4:0]) < NREGS) rd_mux = regs_q[hdr_full[IW-1:0]];
    case (hdr_full[4:0])
      5'd1:    rd_mux = bus.status_in;
      5'd2:    rd_mux = PHY_ID1;
      5'd3:    rd_mux = PHY_ID2;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HUNT: if (rise && !mdio_s && (pre_q >= need)) state_d = S_HDR;
      S_HDR: begin
        if (timeout) state_d = S_HUNT;
        else if (hdr_done) begin
          if (hdr_bad)                        state_d = S_HUNT;
          else if (hdr_full[9:5] != PHY_ADDR) state_d = S_IGNORE;
          else if (hdr_full[11:10] == 2'b10)  state_d = S_READ;
          else                                state_d = S_WRITE;
        end
      end
      default: if (timeout || last_bit) state_d = S_HUNT;
    endcase
  end

  always_comb begin
    busy_c      = (state_q != S_HUNT);
    wr_fire     = (state_q == S_WRITE) && last_bit && ta_ok_q;
    frame_err_d = timeout || (hdr_done && hdr_bad) ||
                  ((state_q == S_WRITE) && last_bit && !ta_ok_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_s1_q <= 1'b0; mdc_s2_q <= 1'b0; mdc_prev_q <= 1'b0;
      mdio_s1_q <= 1'b0; mdio_s2_q <= 1'b0;
      pre_q <= '0; tmr_q <= '0; bit_q <= 5'd1; hdr_q <= '0; regad_q <= '0;
      rdata_q <= '0; wsh_q <= '0; ta_ok_q <= 1'b0;
      mdio_out_q <= 1'b0; mdio_en_q <= 1'b0; wr_strobe_q <= 1'b0; frame_err_q <= 1'b0;
      wr_addr_q <= '0; wr_data_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      mdc_s1_q    <= bus.mdc_in;
      mdc_s2_q    <= mdc_s1_q;
      mdc_prev_q  <= mdc_s2_q;
      mdio_s1_q   <= bus.mdio_in;
      mdio_s2_q   <= mdio_s1_q;
      wr_strobe_q <= wr_fire;
      frame_err_q <= frame_err_d;

      // Count is held at 0 outside HUNT so every frame needs a fresh preamble
      if (state_q != S_HUNT || state_d != S_HUNT) pre_q <= '0;
      else if (rise) pre_q <= !mdio_s ? '0 :
                              (pre_q == PW'(PREAMBLE_BITS)) ? pre_q : pre_q + 1'b1;

      tmr_q <= (state_q == S_HUNT || rise || timeout) ? '0 : tmr_q + 1'b1;

      if (state_q == S_HUNT) bit_q <= 5'd1;
      else if (rise)         bit_q <= bit_q + 1'b1;

      if (state_q == S_HDR && rise) hdr_q <= hdr_full[11:0];
      if (hdr_done) begin
        regad_q <= hdr_full[4:0];
        rdata_q <= rd_mux;
      end

      if (state_q == S_READ && rise) begin
        if (bit_q == 5'd14) begin
          mdio_en_q <= 1'b1; mdio_out_q <= 1'b0;
        end else if (bit_q == 5'd31) begin
          mdio_en_q <= 1'b0; mdio_out_q <= 1'b0;
        end else begin
          mdio_out_q <= rdata_q[15];
          rdata_q    <= {rdata_q[14:0], 1'b0};
        end
      end
      if (timeout) begin
        mdio_en_q <= 1'b0; mdio_out_q <= 1'b0;
      end

      if (state_q == S_WRITE && rise) begin
        if (bit_q == 5'd14)      ta_ok_q <= mdio_s;
        else if (bit_q == 5'd15) ta_ok_q <= ta_ok_q & ~mdio_s;
        else                     wsh_q   <= wdata_full[14:0];
      end

      // Registers 1..3 are read-only views; the strobe still reports the write
      if (wr_fire) begin
        wr_addr_q <= regad_q;
        wr_data_q <= wdata_full;
        for (int i = 0; i < NREGS; i++)
          if (regad_q == 5'(i) && (i == 0 || i >= 4)) regs_q[i] <= wdata_full;
      end
    end
  end

  assign bus.mdio_out  = mdio_out_q;
  assign bus.mdio_en   = mdio_en_q;
  assign bus.ctrl_out  = regs_q[0];
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_c;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: an MDC/MDIO initiator driver plus monitors
// that pop expected writes, read captures and frame errors from queues.
module tb_mdio_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mdio_responder_if bus();
  mdio_responder dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic SUPP = 1'b1;
`else
  localparam logic SUPP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  bit done = 1'b0;

  logic [20:0] exp_wr_q[$];   // {addr, data}
  logic [21:0] exp_rd_q[$];   // {bits driven, captured bits}
  logic [7:0]  exp_err_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [4:0] phy,
                                     input logic [4:0] ra, input logic [17:0] tail);
    return {2'b01, op, phy, ra, tail};
  endfunction

  // One MDC period: data set up while low, 6 clk high, 4 clk low.
  task automatic mdc_bit(input logic b, output logic en_s, output logic busy_s);
    bus.mdio_in = b;
    clks(2);
    bus.mdc_in = 1'b1;
    clks(6);
    en_s   = bus.mdio_en;
    busy_s = bus.busy;
    bus.mdc_in = 1'b0;
    clks(4);
  endtask

  task automatic send_frame(input string name, input int npre, input logic [31:0] fr,
                            input int last, input logic exp_busy, input logic is_read);
    logic en_s, busy_s;
    for (int i = 0; i < npre; i++) mdc_bit(1'b1, en_s, busy_s);
    for (int b = 0; b <= last; b++) begin
      mdc_bit(fr[31-b], en_s, busy_s);
      if (b == 1) chk({name, " busy"}, {31'd0, busy_s}, {31'd0, exp_busy});
      if (is_read && (b == 13 || b == 31))
        chk($sformatf("%s mdio_en bit%0d", name, b), {31'd0, en_s}, 32'd0);
    end
  endtask

  task automatic do_write(input string name, input int npre, input logic [4:0] phy,
                          input logic [4:0] ra, input logic [15:0] d, input logic [1:0] ta,
                          input logic acc, input logic exp_busy);
    if (acc) exp_wr_q.push_back({ra, d});
    send_frame(name, npre, mk(2'b01, phy, ra, {ta, d}), 31, exp_busy, 1'b0);
  endtask

  task automatic do_read(input string name, input logic [4:0] phy, input logic [4:0] ra,
                         input logic acc, input logic [15:0] d);
    if (acc) exp_rd_q.push_back({5'd17, 1'b0, d});
    send_frame(name, 32, mk(2'b10, phy, ra, 18'h3FFFF), 31, 1'b1, 1'b1);
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (bus.wr_strobe) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_strobe unexpected got %h required none", {bus.wr_addr, bus.wr_data});
      end else begin
        logic [20:0] e;
        e = exp_wr_q.pop_front();
        if ({bus.wr_addr, bus.wr_data} !== e) begin
          errors++;
          $display("FAIL wr_strobe got %h required %h", {bus.wr_addr, bus.wr_data}, e);
        end
      end
    end
  end

  // Frame-error monitor
  always @(negedge clk) begin
    if (bus.frame_err) begin
      checks++;
      err_seen++;
      if (exp_err_q.size() == 0) begin
        errors++;
        $display("FAIL frame_err unexpected got 1 required 0");
      end else begin
        void'(exp_err_q.pop_front());
      end
    end
  end

  // Read monitor: collect driven bits on MDC falls, compare when drive releases
  logic [16:0] cap = '0;
  int ncap = 0;
  always @(negedge bus.mdc_in) begin
    if (bus.mdio_en) begin
      cap = {cap[15:0], bus.mdio_out};
      ncap++;
    end else if (ncap != 0) begin
      logic [21:0] got, e;
      got = {5'(ncap), cap};
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL read drive unexpected got %h required none", got);
      end else begin
        e = exp_rd_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL read drive got %h required %h", got, e);
        end
      end
      ncap = 0;
      cap  = '0;
    end
  end

  initial begin
    #2ms;
    if (!done) begin
      errors++;
      $display("FAIL watchdog got timeout required completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    int e0;
    bus.mdc_in    = 1'b0;
    bus.mdio_in   = 1'b1;
    bus.status_in = 16'h0000;
    clks(3);
    chk("rst mdio_en",   {31'd0, bus.mdio_en},   32'd0);
    chk("rst mdio_out",  {31'd0, bus.mdio_out},  32'd0);
    chk("rst busy",      {31'd0, bus.busy},      32'd0);
    chk("rst wr_strobe", {31'd0, bus.wr_strobe}, 32'd0);
    chk("rst frame_err", {31'd0, bus.frame_err}, 32'd0);
    chk("rst ctrl_out",  {16'd0, bus.ctrl_out},  32'd0);
    rst = 1'b0;
    clks(3);

    do_write("wr5", 32, 5'd1, 5'd5, 16'hA5C3, 2'b10, 1'b1, 1'b1);
    do_read("rd5", 5'd1, 5'd5, 1'b1, 16'hA5C3);
    bus.status_in = 16'h782D;
    do_read("rd1", 5'd1, 5'd1, 1'b1, 16'h782D);
    do_read("rd2", 5'd1, 5'd2, 1'b1, 16'h0022);
    do_read("rd20", 5'd1, 5'd20, 1'b1, 16'h0000);
    do_write("wr2", 32, 5'd1, 5'd2, 16'hFFFF, 2'b10, 1'b1, 1'b1);
    do_read("rd2b", 5'd1, 5'd2, 1'b1, 16'h0022);
    do_write("wr0", 32, 5'd1, 5'd0, 16'h1234, 2'b10, 1'b1, 1'b1);
    clks(2);
    chk("ctrl_out", {16'd0, bus.ctrl_out}, 32'h1234);
    do_read("rd3", 5'd1, 5'd3, 1'b1, 16'h1560);

    // Other PHY, then an immediately following frame to us
    do_read("phy3", 5'd3, 5'd5, 1'b0, 16'h0000);
    do_read("rd0", 5'd1, 5'd0, 1'b1, 16'h1234);

    // Short preambles: only accepted when preamble suppression is built in
    do_write("pre31", 31, 5'd1, 5'd6, 16'h0F0F, 2'b10, SUPP, SUPP);
    do_read("rd6", 5'd1, 5'd6, 1'b1, SUPP ? 16'h0F0F : 16'h0000);
    do_write("pre1", 1, 5'd1, 5'd7, 16'h5A5A, 2'b10, SUPP, SUPP);
    do_read("rd7", 5'd1, 5'd7, 1'b1, SUPP ? 16'h5A5A : 16'h0000);

    exp_err_q.push_back(8'd1);
    send_frame("op11", 32, mk(2'b11, 5'd1, 5'd5, 18'h3FFFF), 31, 1'b1, 1'b0);
    exp_err_q.push_back(8'd2);
    do_write("badta", 32, 5'd1, 5'd5, 16'h1111, 2'b11, 1'b0, 1'b1);
    do_read("rd5b", 5'd1, 5'd5, 1'b1, 16'hA5C3);

    // MDC stops after bit 20: TA0 + A5C3[15:10] = 7'b0101001 already driven
    exp_rd_q.push_back({5'd7, 17'h00029});
    exp_err_q.push_back(8'd3);
    e0 = err_seen;
    send_frame("tmo", 32, mk(2'b10, 5'd1, 5'd5, 18'h3FFFF), 20, 1'b1, 1'b1);
    clks(4000);
    chk("tmo mdio_en held", {31'd0, bus.mdio_en}, 32'd1);
    for (int i = 0; i < 300 && err_seen == e0; i++) clks(1);
    chk("tmo frame_err seen", {31'd0, err_seen != e0}, 32'd1);
    chk("tmo mdio_en", {31'd0, bus.mdio_en}, 32'd0);
    chk("tmo busy",    {31'd0, bus.busy},    32'd0);
    do_read("rd5c", 5'd1, 5'd5, 1'b1, 16'hA5C3);

    // Reset mid-read after bit 18: TA0 + A5C3[15:12] = 5'b01010 driven
    exp_rd_q.push_back({5'd5, 17'h0000A});
    send_frame("rstmid", 32, mk(2'b10, 5'd1, 5'd5, 18'h3FFFF), 18, 1'b1, 1'b1);
    chk("rstmid mdio_en before", {31'd0, bus.mdio_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid mdio_en",  {31'd0, bus.mdio_en}, 32'd0);
    chk("rstmid ctrl_out", {16'd0, bus.ctrl_out}, 32'd0);
    chk("rstmid busy",     {31'd0, bus.busy},    32'd0);
    clks(3);
    rst = 1'b0;
    clks(3);
    do_read("rd5d", 5'd1, 5'd5, 1'b1, 16'h0000);
    clks(20);

    chk("pending writes", exp_wr_q.size(), 32'd0);
    chk("pending reads",  exp_rd_q.size(), 32'd0);
    chk("pending errors", exp_err_q.size(), 32'd0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
